// File: rtl/mc_voltage_scaler.sv
// Per-channel gain scaler: out = sat(in_data * gain[in_ch] / DIV), two-stage valid/ready pipe.
// Define MC_VOLTAGE_SCALER_ROUND_EN to round the quotient half up instead of truncating.
module mc_voltage_scaler #(
  parameter int unsigned IN_W     = 12,
  parameter int unsigned OUT_W    = 12,
  parameter int unsigned CH_N     = 13,
  parameter int unsigned CH_W     = 4,
  parameter int unsigned GAIN_W   = 10,
  parameter int unsigned GAIN_RST = 812,
  parameter int unsigned DIV      = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [IN_W-1:0]   in_data,
  input  logic              gain_we,
  input  logic [CH_W-1:0]   gain_ch,
  input  logic [GAIN_W-1:0] gain_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat
);

  localparam int unsigned PW = IN_W + GAIN_W;

  localparam logic [PW:0]   DIV_L  = (PW+1)'(DIV);
  localparam logic [PW:0]   MAX_Q  = (PW+1)'((64'd1 << OUT_W) - 64'd1);
  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CH_N);
`ifdef MC_VOLTAGE_SCALER_ROUND_EN
  localparam logic [PW:0]   BIAS   = (PW+1)'(DIV / 2);
`else
  localparam logic [PW:0]   BIAS   = '0;
`endif

  logic [GAIN_W-1:0] gain_q [CH_N];
  logic [GAIN_W-1:0] gain_d [CH_N];

  logic            s1_valid_q, s1_valid_d;
  logic [PW-1:0]   s1_prod_q, s1_prod_d;
  logic [CH_W-1:0] s1_ch_q, s1_ch_d;

  logic             s2_valid_q, s2_valid_d;
  logic [CH_W-1:0]  s2_ch_q, s2_ch_d;
  logic [OUT_W-1:0] s2_data_q, s2_data_d;
  logic             s2_sat_q, s2_sat_d;

  logic              s1_adv, s2_adv;
  logic              in_ch_ok, gain_ch_ok;
  logic [GAIN_W-1:0] gain_sel;
  logic [PW:0]       num, quot;
  logic              over;

  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    in_ready   = !rst && s1_adv;
    in_ch_ok   = {1'b0, in_ch} < CH_LIM;
    gain_ch_ok = {1'b0, gain_ch} < CH_LIM;
    // Unmapped channels multiply by zero so they flow through as a zero result.
    gain_sel   = in_ch_ok ? gain_q[in_ch] : '0;

    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_ch_d    = s1_ch_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_prod_d = PW'(in_data) * PW'(gain_sel);
        s1_ch_d   = in_ch;
      end
    end

    num  = {1'b0, s1_prod_q} + BIAS;
    quot = num / DIV_L;
    over = quot > MAX_Q;

    s2_valid_d = s2_valid_q;
    s2_ch_d    = s2_ch_q;
    s2_data_d  = s2_data_q;
    s2_sat_d   = s2_sat_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_ch_d   = s1_ch_q;
        s2_sat_d  = over;
        s2_data_d = over ? MAX_Q[OUT_W-1:0] : quot[OUT_W-1:0];
      end
    end

    // Written value lands at the edge, so a sample in the same cycle still sees the old gain.
    gain_d = gain_q;
    if (gain_we && gain_ch_ok) begin
      gain_d[gain_ch] = gain_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gain_q     <= '{default: GAIN_W'(GAIN_RST)};
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_ch_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_ch_q    <= '0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
    end else begin
      gain_q     <= gain_d;
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_ch_q    <= s1_ch_d;
      s2_valid_q <= s2_valid_d;
      s2_ch_q    <= s2_ch_d;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_ch    = s2_ch_q;
  assign out_data  = s2_data_q;
  assign out_sat   = s2_sat_q;

endmodule

// File: tb/tb_mc_voltage_scaler.sv
// Bench for mc_voltage_scaler: directed literal cases plus randomized traffic against a
// queue-based reference model checked on every output transfer.
module tb_mc_voltage_scaler;

  localparam int CHN  = 13;
  localparam int DIVV = 1000;
  localparam int OMAX = 4095;
`ifdef MC_VOLTAGE_SCALER_ROUND_EN
  localparam int RND      = 1;
  localparam int EXP_TWO  = 2;
  localparam int EXP_G100 = 410;
`else
  localparam int RND      = 0;
  localparam int EXP_TWO  = 1;
  localparam int EXP_G100 = 409;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ch;
  logic [11:0] in_data;
  logic        gain_we;
  logic [3:0]  gain_ch;
  logic [9:0]  gain_val;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_ch;
  logic [11:0] out_data;
  logic        out_sat;

  mc_voltage_scaler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .gain_we   (gain_we),
    .gain_ch   (gain_ch),
    .gain_val  (gain_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int ch;
    int data;
    int sat;
  } exp_t;

  exp_t expq[$];
  int   gains[CHN];

  function automatic exp_t model(input int ch, input int data);
    exp_t   e;
    longint p, q;
    e.ch = ch;
    if (ch >= CHN) begin
      e.data = 0;
      e.sat  = 0;
    end else begin
      p = longint'(data) * longint'(gains[ch]);
      q = (p + (RND != 0 ? DIVV / 2 : 0)) / DIVV;
      e.sat  = (q > OMAX) ? 1 : 0;
      e.data = (q > OMAX) ? OMAX : int'(q);
    end
    return e;
  endfunction

  // Reference monitor: sampled mid-cycle, so it sees exactly what the next edge will commit.
  logic        rst_prev = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  h_ch;
  logic [11:0] h_data;
  logic        h_sat;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_in_ready_low", in_ready, 0);
      if (rst_prev) chk("rst_out_valid_low", out_valid, 0);
      expq.delete();
      for (int i = 0; i < CHN; i++) gains[i] = 812;
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_ch", out_ch, h_ch);
        chk("hold_data", out_data, h_data);
        chk("hold_sat", out_sat, h_sat);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("out_without_input", out_valid, 0);
        end else begin
          e = expq.pop_front();
          chk("out_ch", out_ch, e.ch);
          chk("out_data", out_data, e.data);
          chk("out_sat", out_sat, e.sat);
        end
      end
      if (in_valid && in_ready) expq.push_back(model(int'(in_ch), int'(in_data)));
      if (gain_we && int'(gain_ch) < CHN) gains[gain_ch] = int'(gain_val);
      hold   = out_valid && !out_ready;
      h_ch   = out_ch;
      h_data = out_data;
      h_sat  = out_sat;
    end
    rst_prev = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample with out_ready high; checks the two-cycle latency and result.
  task automatic single(input int ch, input int data, input int exp_d, input int exp_s,
                        input string tag);
    in_valid = 1'b1;
    in_ch    = 4'(ch);
    in_data  = 12'(data);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    gain_we  = 1'b0;
    @(negedge clk);
    chk({tag, "_not_yet"}, out_valid, 0);
    tick();
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_sat"}, out_sat, exp_s);
    chk({tag, "_ch"}, out_ch, ch);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    logic acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_data   = '0;
    gain_we   = 1'b0;
    gain_ch   = '0;
    gain_val  = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_ch", out_ch, 0);
    chk("reset_out_sat", out_sat, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    tick();

    single(0, 4095, 3325, 0, "full_scale");
    single(0, 2, EXP_TWO, 0, "tiny");

    gain_we = 1'b1; gain_ch = 4'd5; gain_val = 10'd1023;
    tick();
    gain_we = 1'b0;
    single(5, 4095, 4095, 1, "saturate");
    // Same-cycle gain write must not affect this sample.
    gain_we = 1'b1; gain_ch = 4'd5; gain_val = 10'd100;
    single(5, 4095, 4095, 1, "same_cycle_write");
    single(5, 4095, EXP_G100, 0, "new_gain");
    gain_we = 1'b1; gain_ch = 4'd13; gain_val = 10'd7;
    tick();
    gain_we = 1'b0;
    single(13, 4095, 0, 0, "bad_ch");

    // Backpressure: out_ready low for three cycles while four samples are offered.
    out_ready = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 20 && sent < 4; cyc++) begin
      in_valid = 1'b1;
      in_ch    = 4'(sent);
      in_data  = 12'(1000 + 700 * sent);
      if (cyc == 3) out_ready = 1'b1;
      @(negedge clk);
      if (cyc == 1) chk("bp_in_ready_second", in_ready, 1);
      if (cyc == 2) begin
        chk("bp_in_ready_drop", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
      end
      acc = in_ready;
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", sent, 4);
    repeat (5) tick();
    chk("bp_drained", expq.size(), 0);

    // Reset with two samples in flight.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_ch = 4'd0; in_data = 12'd4095;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_no_out", out_valid, 0);
      tick();
    end
    single(5, 4095, 3325, 0, "gain_restored");
    single(13, 4095, 0, 0, "ch13_after_rst");

    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_ch     = 4'($urandom_range(0, 15));
      in_data   = ($urandom_range(0, 3) == 0) ? 12'd4095 : 12'($urandom_range(0, 4095));
      gain_we   = ($urandom_range(0, 7) == 0);
      gain_ch   = 4'($urandom_range(0, 15));
      gain_val  = 10'($urandom_range(0, 1023));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; gain_we = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    chk("final_drain", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_voltage_scaler.md
MC_VOLTAGE_SCALER -- requirements
Module: mc_voltage_scaler

Interface
REQ-001 SHALL have parameter IN_W, 12, raw ADC sample width.
REQ-002 SHALL have parameter OUT_W, 12, scaled output width.
REQ-003 SHALL have parameter CH_N, 13, number of channels.
REQ-004 SHALL have parameter CH_W, 4, channel tag width; CH_N <= 2^CH_W.
REQ-005 SHALL have parameter GAIN_W, 10, per-channel gain width.
REQ-006 SHALL have parameter GAIN_RST, 812, reset value of every channel gain.
REQ-007 SHALL have parameter DIV, 1000, fixed divisor (>0).
REQ-008 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-009 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-010 SHALL have port in_valid  input  1  input sample valid.
REQ-011 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-012 SHALL have port in_ch  input  CH_W  channel of input sample.
REQ-013 SHALL have port in_data  input  IN_W  unsigned raw sample.
REQ-014 SHALL have port gain_we  input  1  gain register write strobe.
REQ-015 SHALL have port gain_ch  input  CH_W  channel to write.
REQ-016 SHALL have port gain_val  input  GAIN_W  new unsigned gain.
REQ-017 SHALL have port out_valid  output  1  scaled result valid.
REQ-018 SHALL have port out_ready  input  1  consumer accepts result.
REQ-019 SHALL have port out_ch  output  CH_W  channel tag of result.
REQ-020 SHALL have port out_data  output  OUT_W  scaled result.
REQ-021 SHALL have port out_sat  output  1  result was clipped.

Function
REQ-022 Transfer SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-023 Pipeline SHALL be 2 registered stages: S1 = in_data*gain[in_ch] (IN_W+GAIN_W bits, tag, valid); S2 = quotient, tag, sat, valid driving out_*.
REQ-024 Latency SHALL be 2 cycles from input transfer to out_valid with out_ready held high; throughput 1 sample/cycle.
REQ-025 Each stage SHALL advance when it is empty or its successor advances; in_ready = S1 empty or S1 advancing (bubbles collapse).
REQ-026 With out_ready low, out_valid/out_ch/out_data/out_sat SHALL hold stable until transfer.
REQ-027 Quotient SHALL be floor(product/DIV) (rounding per REQ-036).
REQ-028 Quotient > 2^OUT_W-1 SHALL output 2^OUT_W-1 with out_sat=1; otherwise out_sat=0.
REQ-029 Gain SHALL be sampled at input transfer; a gain write in the same cycle affects only later samples.
REQ-030 gain_we with gain_ch >= CH_N SHALL be ignored.
REQ-031 Input with in_ch >= CH_N SHALL be accepted and yield out_data=0, out_sat=0, out_ch=in_ch.
REQ-032 Results SHALL leave in acceptance order; no sample lost or duplicated under any out_ready pattern.

Reset
REQ-033 On rst: S1/S2 valid cleared, out_valid=0, out_data=0, out_ch=0, out_sat=0, all gains=GAIN_RST.
REQ-034 rst mid-operation SHALL discard in-flight samples; in_ready=1 from the first cycle after rst deasserts.
REQ-035 in_ready SHALL be 0 while rst is high.

Configuration
REQ-036 Macro MC_VOLTAGE_SCALER_ROUND_EN defined: quotient = floor((product + DIV/2)/DIV) (round half up); undefined: floor(product/DIV); saturation applied after either.

Verification
REQ-037 Default gains, in_ch=0, in_data=4095, out_ready=1 -> 2 cycles later out_data=3325, out_sat=0, out_ch=0.
REQ-038 in_data=2, gain 812 -> out_data=1 without macro, 2 with MC_VOLTAGE_SCALER_ROUND_EN.
REQ-039 Write gain_ch=5 gain_val=1023, then in_ch=5 in_data=4095 -> out_data=4095, out_sat=1; same-cycle write+sample on ch 5 uses old gain.
REQ-040 4 back-to-back samples, out_ready low 3 cycles -> in_ready drops after 2 held, out_* stable; all 4 results emerge in order.
REQ-041 rst asserted with 2 samples in flight -> no out_valid after rst; gains back to 812; in_ch=13 sample -> out_data=0.
